// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Pipelined data-memory responder. Accepts one read or write
//               per cycle over a valid/ready handshake and returns read data
//               a fixed LATENCY cycles later, holding the whole pipeline
//               while the requester applies response backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy
);

  // Word index bits sit just above the byte-select bit 0.
  localparam int c_IDX_W = $clog2(MEM_WORDS);

  // Storage array; deliberately not reset so contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // Pipeline stages: valid bits are reset, data is gated at the output.
  logic [LATENCY-1:0]    r_valid;
  logic [DATA_WIDTH-1:0] r_data [LATENCY];

  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_advance;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_unused;

  // Upper address bits and bit 0 do not select a word, so addresses wrap.
  assign w_idx    = req_addr[c_IDX_W:1];
  assign w_unused = &{1'b0, req_addr};

  // The pipeline only freezes when a valid response is being refused; a
  // bubble in the last stage never blocks progress.
  assign w_advance   = ~(r_valid[LATENCY-1] & ~resp_ready);
  assign req_ready   = w_advance;
  assign w_accept    = req_valid & w_advance;
  assign w_rd_accept = w_accept & ~req_wr;

  // Array write at the acceptance edge; suppressed while held in reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && req_wr) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  // Stage valid bits: a write or an idle cycle enters as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= w_rd_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Stage data: stage 0 samples the array at the acceptance edge, so a write
  // accepted on an earlier edge is already in the array.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_data[0] <= r_mem[w_idx];
      for (int i = 1; i < LATENCY; i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign resp_valid = r_valid[LATENCY-1];
  assign resp_rdata = r_valid[LATENCY-1] ? r_data[LATENCY-1] : '0;
  assign busy       = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Self-checking bench for memory_responder. Directed vectors on
//               a LATENCY=4 instance plus scoreboarded random traffic on
//               LATENCY=1 and LATENCY=8 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        busy;

  int   n_checks = 0;
  int   n_errors = 0;
  logic sweep_go = 1'b0;

  always #5 clk = ~clk;

  memory_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_WORDS(1024), .LATENCY(LAT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .busy(busy)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid = v;
    req_wr    = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Issue one read into an empty pipeline and expect the response exactly LAT cycles later.
  task automatic read_expect(input string tag, input logic [15:0] a, input logic [15:0] exp);
    drive(1'b1, 1'b0, a, 16'h0);
    @(negedge clk);
    chk({tag, "_v0"}, resp_valid, 0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk({tag, "_valid"}, resp_valid, (c == LAT));
      if (c == LAT) chk({tag, "_data"}, resp_rdata, exp);
      tick();
    end
  endtask

  // Random-traffic instances with a scoreboard each.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SL = (g == 0) ? 1 : 8;

    logic        s_req_valid = 1'b0;
    logic        s_req_wr = 1'b0;
    logic [15:0] s_req_addr = '0;
    logic [15:0] s_req_wdata = '0;
    logic        s_resp_ready = 1'b1;
    logic        s_req_ready;
    logic        s_resp_valid;
    logic [15:0] s_resp_rdata;
    logic        s_busy;

    logic [15:0] model [16];
    logic [15:0] q_data [$];
    int          q_cyc [$];
    int          q_stl [$];
    int          cyc = 0;
    int          stalls = 0;
    bit          presented = 1'b0;
    bit          done = 1'b0;

    memory_responder #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_WORDS(1024), .LATENCY(SL)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .req_wr(s_req_wr), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
      .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
      .resp_rdata(s_resp_rdata), .busy(s_busy)
    );

    initial begin
      wait (sweep_go);
      tick();
      for (int i = 0; i < 16; i++) begin
        s_req_valid = 1'b1;
        s_req_wr    = 1'b1;
        s_req_addr  = 16'(i * 2);
        s_req_wdata = 16'($urandom);
        tick();
      end
      for (int i = 0; i < 400; i++) begin
        s_req_valid  = ($urandom_range(0, 3) != 0);
        s_req_wr     = ($urandom_range(0, 2) == 0);
        s_req_addr   = 16'($urandom) & 16'hF81F;
        s_req_wdata  = 16'($urandom);
        s_resp_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      s_req_valid  = 1'b0;
      s_resp_ready = 1'b1;
      repeat (SL + 4) tick();
      chk("sweep_drained", q_data.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (sweep_go && !done) begin
        chk("sweep_ready", s_req_ready, !(s_resp_valid && !s_resp_ready));
        if (s_resp_valid) begin
          chk("sweep_q_nonempty", (q_data.size() != 0), 1);
          if (q_data.size() != 0) begin
            if (!presented) begin
              chk("sweep_latency", cyc, q_cyc[0] + SL + (stalls - q_stl[0]));
              presented = 1'b1;
            end
            chk("sweep_data", s_resp_rdata, q_data[0]);
          end
          if (s_resp_ready) begin
            if (q_data.size() != 0) begin
              void'(q_data.pop_front());
              void'(q_cyc.pop_front());
              void'(q_stl.pop_front());
            end
            presented = 1'b0;
          end else begin
            stalls++;
          end
        end else begin
          chk("sweep_rdata_zero", s_resp_rdata, 0);
        end
        if (s_req_valid && s_req_ready) begin
          if (s_req_wr) begin
            model[s_req_addr[4:1]] = s_req_wdata;
          end else begin
            q_data.push_back(model[s_req_addr[4:1]]);
            q_cyc.push_back(cyc);
            q_stl.push_back(stalls);
          end
        end
        cyc++;
      end
    end
  end

  logic [15:0] t3_exp [4];
  logic [15:0] t3_addr [4];

  initial begin
    t3_addr = '{16'h0000, 16'h0002, 16'h0004, 16'h0010};
    t3_exp  = '{16'h1111, 16'h2222, 16'h3333, 16'hBEEF};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;

    // Test 1: write then read, response exactly in cycle 5
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    chk("t1_wr_noresp", resp_valid, 0);
    tick();
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    chk("t1_wr_nobusy", busy, 0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk("t1_valid", resp_valid, (c == 5));
      chk("t1_busy", busy, (c <= 5));
      chk("t1_rdata", resp_rdata, (c == 5) ? 16'hBEEF : 16'h0);
      tick();
    end

    // Test 2: back-to-back reads give back-to-back responses
    write_word(16'h0000, 16'h1111);
    write_word(16'h0002, 16'h2222);
    write_word(16'h0004, 16'h3333);
    for (int c = 0; c <= 7; c++) begin
      if (c < 3) drive(1'b1, 1'b0, 16'(c * 2), 16'h0);
      else drive(1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("t2_valid", resp_valid, (c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) chk("t2_data", resp_rdata, 16'h1111 * (c - 3));
      if (c >= 3) chk("t2_busy", busy, (c <= 6));
      tick();
    end

    // Test 3: backpressure holds the pipeline and blocks a write
    for (int c = 0; c <= 11; c++) begin
      resp_ready = !(c >= 4 && c <= 6);
      if (c < 4) drive(1'b1, 1'b0, t3_addr[c], 16'h0);
      else if (c == 5) drive(1'b1, 1'b1, 16'h0000, 16'hDEAD);
      else drive(1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk("t3_stall_valid", resp_valid, 1);
        chk("t3_stall_data", resp_rdata, 16'h1111);
        chk("t3_stall_ready", req_ready, 0);
      end else if (c >= 7 && c <= 10) begin
        chk("t3_rel_valid", resp_valid, 1);
        chk("t3_rel_data", resp_rdata, t3_exp[c-7]);
      end else if (c == 11) begin
        chk("t3_end_valid", resp_valid, 0);
      end
      tick();
    end
    resp_ready = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    read_expect("t3_reread", 16'h0000, 16'h1111);

    // Test 4: address wrap and ignored bit 0
    write_word(16'h0806, 16'hA5A5);
    read_expect("t4_wrap", 16'h0006, 16'hA5A5);
    read_expect("t4_bit0", 16'h0007, 16'hA5A5);

    // Test 5: asynchronous reset with reads in flight
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    drive(1'b1, 1'b0, 16'h0006, 16'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) tick();
    #2;
    chk("t5_pre_valid", resp_valid, 1);
    chk("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", resp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdata", resp_rdata, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_no_stale", resp_valid, 0);
      tick();
    end
    read_expect("t5_reread", 16'h0010, 16'hBEEF);

    // Test 6: LATENCY=1 and LATENCY=8 random sweeps
    sweep_go = 1'b1;
    for (int i = 0; i < 3000 && !(g_sweep[0].done && g_sweep[1].done); i++) begin
      @(posedge clk);
    end
    chk("sweep_done", (g_sweep[0].done && g_sweep[1].done), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_responder.md
Name: memory_responder

Overview:
Multi-cycle, pipelined data-memory responder: the memory-side end of the CPU's data memory request interface.
- Accepts one read or write request per cycle through a valid/ready handshake.
- Returns read data after a fixed LATENCY with response backpressure.
- Replaces the single-cycle data memory wherever the pipeline must tolerate realistic memory timing.

Parameters:
ADDR_WIDTH, 16, byte address width; bit 0 ignored (word addressed).
DATA_WIDTH, 16, data word width.
MEM_WORDS, 1024, storage depth in words; power of two.
LATENCY, 4, cycles from read acceptance to resp_valid; legal range 1..8.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset; asynchronous, active-low.
req_valid  input  1  request present this cycle.
req_ready  output  1  responder can accept a request this cycle.
req_wr  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  write data.
resp_valid  output  1  read data present on resp_rdata.
resp_ready  input  1  requester consumes the response this cycle.
resp_rdata  output  DATA_WIDTH  read data; 0 whenever resp_valid=0.
busy  output  1  at least one read in flight (any pipeline stage valid).

Behaviour:
- Word index = req_addr[log2(MEM_WORDS):1]. Upper address bits are ignored, so addresses wrap modulo 2*MEM_WORDS bytes.
- Acceptance: a request is accepted at a rising edge when req_valid=1 and req_ready=1.
- req_ready is combinational: req_ready = ~(resp_valid & ~resp_ready).
- Write:
  - Array updated at the acceptance edge.
  - Occupies one pipeline slot as a bubble (no response).
  - Never produces resp_valid.
- Read:
  - Array sampled at the acceptance edge.
  - A write accepted on an earlier edge is always visible.
  - Only one request per cycle, so there is no same-edge hazard.
- Pipeline: LATENCY stages, each holding {valid, data}. Stage 0 loads {read_accepted, array[index]}; each later stage loads from the previous stage.
  - Outputs: resp_valid = stage[LATENCY-1].valid; resp_rdata = stage[LATENCY-1].data, gated to 0 when not valid.
  - Timing: a read accepted at the end of cycle N has resp_valid=1 in cycle N+LATENCY, assuming no stall.
  - Back-to-back reads give back-to-back responses: throughput 1 per cycle.
- Stall:
  - When resp_valid=1 and resp_ready=0, every stage holds its value and req_ready=0.
  - No request is accepted and no array write occurs.
  - Stall ends in the first cycle resp_ready=1: the response is consumed and the pipeline advances on that edge.
- Bubble slots: if resp_valid=0, the pipeline always advances, even while resp_ready=0.
- Response ordering: responses are returned strictly in acceptance order, never dropped, never duplicated.
- Reset (async assert, sync-safe deassert):
  - All stage valid bits clear immediately.
  - Outputs forced to: resp_valid=0, resp_rdata=0, busy=0, req_ready=1.
  - Reset mid-operation discards all in-flight reads.
  - Array contents are not cleared by reset.
- busy = OR of all stage valid bits (writes excluded); combinational from registers.
- Requests with req_valid=0 inject a bubble. Array is untouched.

Test Plan:
1. Reset, LATENCY=4. Write 0xBEEF to 0x0010 in cycle 0. Read 0x0010 in cycle 1 -> resp_valid=1 with resp_rdata=0xBEEF in cycle 5 only; no response is generated for the write.
2. Write 0x1111 to 0x0000, 0x2222 to 0x0002, 0x3333 to 0x0004. Then issue 3 back-to-back reads of those addresses with resp_ready=1 -> responses 0x1111, 0x2222, 0x3333 in 3 consecutive cycles; busy falls the cycle after the last response.
3. Backpressure: issue 4 back-to-back reads, resp_ready=0 when the first response appears, held 3 cycles -> resp_valid stays 1, data held, req_ready=0. A write presented during the stall is not applied (re-read shows the old value). On release, 4 responses come in order, one per cycle.
4. Address wrap, MEM_WORDS=1024: write 0xA5A5 to 0x0806, read 0x0006 -> 0xA5A5. Read with req_addr bit 0 = 1 (0x0007) -> 0xA5A5.
5. Reset mid-flight: 2 reads outstanding, pulse rst_n low asynchronously mid-cycle -> resp_valid and busy drop to 0 immediately, no stale response after release. A previously written word still reads back correctly.
6. Sweep LATENCY=1 and LATENCY=8 with a random read/write mix and random resp_ready against a scoreboard -> every read matches the last accepted write to that word; latency exactly LATENCY with no stall.
